uart_rx_os: RTL and testbench

- Oversampling UART receiver; the receive-side counterpart of the team's uart_tx.
- Recovers 8N1 frames (optionally 8E1) from an asynchronous serial line, sampling each bit at mid-bit with an internally generated oversample tick.
- Delivers each byte on a parallel bus with a one-cycle valid pulse and flags framing errors.
- Sits between the pad-side serial input and the byte consumer (FIFO or register block).

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_os_if.sv | 37 +++
 rtl/uart_os_tick.sv | 26 ++
 rtl/uart_rx_os.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_os.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default frame geometry,
// used by both the transmitter and the oversampling receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int OS_RATE_DEF   = 16;
    localparam int DATA_BITS_DEF = 8;

endpackage

// File: rtl/uart_rx_os_if.sv
// Byte-side bus of the oversampling UART receiver (parity_err present only
// when UART_RX_PARITY_EN is defined).
interface uart_rx_os_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
);
    // Handshake: there is no ready. rx_valid, frame_err and parity_err are
    // single-cycle pulses, at most one high at a time; rx_data changes only
    // together with rx_valid and the consumer must take it in that cycle.
    logic                 rx_serial;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;
    state_t               state;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        input  rx_serial,
        output rx_data, rx_valid, frame_err, busy, state
`ifdef UART_RX_PARITY_EN
        , parity_err
`endif
    );

    modport slave (
        output rx_serial,
        input  rx_data, rx_valid, frame_err, busy, state
`ifdef UART_RX_PARITY_EN
        , parity_err
`endif
    );

endinterface

// File: rtl/uart_os_tick.sv
// Free-running CLK_DIV prescaler producing a one-cycle oversample tick.
module uart_os_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 8N1, or 8E1 when UART_RX_PARITY_EN is defined.
// Samples each bit at mid-bit and pulses rx_valid / frame_err per frame.
import uart_pkg::*;

module uart_rx_os #(
    parameter int CLK_DIV   = 4,
    parameter int OS_RATE   = OS_RATE_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_os_if.master  bus
);
    localparam int OS_W = $clog2(OS_RATE);
    localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [OS_W-1:0] OS_HALF  = OS_W'(OS_RATE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OS_RATE - 1);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_BITS - 1);

    logic sync1, rxs, tick;

    state_t               state, state_nxt;
    logic [OS_W-1:0]      os_cnt, os_nxt;
    logic [BC_W-1:0]      bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shreg, sh_nxt, data_q, data_nxt;
    logic                 armed, armed_nxt;
    logic                 valid_q, valid_nxt, ferr_q, ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_nxt, perr_q, perr_nxt;
`endif

    uart_os_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Synchronizer resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= bus.rx_serial;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            data_q  <= '0;
            armed   <= 1'b1;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            os_cnt  <= os_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= sh_nxt;
            data_q  <= data_nxt;
            armed   <= armed_nxt;
            valid_q <= valid_nxt;
            ferr_q  <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_nxt;
            perr_q  <= perr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        os_nxt    = os_cnt;
        bit_nxt   = bit_cnt;
        sh_nxt    = shreg;
        data_nxt  = data_q;
        armed_nxt = armed;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt   = par_q;
        perr_nxt  = 1'b0;
`endif
        if (tick) begin
            case (state)
                IDLE: begin
                    if (rxs) armed_nxt = 1'b1;
                    if (armed && !rxs) begin
                        state_nxt = START;
                        os_nxt    = '0;
                    end
                end
                START: begin
                    if (os_cnt == OS_HALF) begin
                        os_nxt    = '0;
                        bit_nxt   = '0;
                        state_nxt = rxs ? IDLE : DATA;
                    end else begin
                        os_nxt = os_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (os_cnt == OS_LAST) begin
                        os_nxt = '0;
                        sh_nxt = {rxs, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end else begin
                            bit_nxt = bit_cnt + 1'b1;
                        end
                    end else begin
                        os_nxt = os_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (os_cnt == OS_LAST) begin
                        os_nxt    = '0;
                        par_nxt   = rxs;
                        state_nxt = STOP;
                    end else begin
                        os_nxt = os_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Leave at mid-stop-bit so a zero-gap next start edge is not missed.
                    if (os_cnt == OS_LAST) begin
                        os_nxt    = '0;
                        state_nxt = IDLE;
                        if (!rxs) begin
                            ferr_nxt  = 1'b1;
                            armed_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
                        end else if (^{shreg, par_q}) begin
                            perr_nxt = 1'b1;
`endif
                        end else begin
                            valid_nxt = 1'b1;
                            data_nxt  = shreg;
                        end
                    end else begin
                        os_nxt = os_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state != IDLE);
    assign bus.state     = state;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os (CLK_DIV=4, OS_RATE=16: 64 clk per bit).
// Honours UART_RX_PARITY_EN when the build defines it.
module tb_uart_rx_os;
    localparam int BIT_CLK = 64;
    localparam logic [1:0] K_VALID = 2'd0;
    localparam logic [1:0] K_FERR  = 2'd1;
    localparam logic [1:0] K_PERR  = 2'd2;
    localparam logic [1:0] K_MULTI = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic perr;
    int   checks = 0;
    int   errors = 0;

    logic [9:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_os_if #(.DATA_BITS(8)) bus();

    uart_rx_os #(.CLK_DIV(4), .OS_RATE(16), .DATA_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef UART_RX_PARITY_EN
    assign perr = bus.parity_err;
`else
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference model: what a frame must produce, from the frame contents alone.
    task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
        if (!stop) begin
            exp_q.push_back({K_FERR, last_good});
`ifdef UART_RX_PARITY_EN
        end else if ((^d) ^ par) begin
            exp_q.push_back({K_PERR, last_good});
`endif
        end else begin
            last_good = d;
            exp_q.push_back({K_VALID, d});
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop);
        bus.rx_serial = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            bus.rx_serial = d[i];
            wait_clk(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx_serial = par;
        wait_clk(BIT_CLK);
`endif
        bus.rx_serial = stop;
        wait_clk(BIT_CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        model_frame(d, par, stop);
        drive_frame(d, par, stop);
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clk) begin
        logic [1:0] kind;
        logic [9:0] e;
        if (!rst && (bus.rx_valid || bus.frame_err || perr)) begin
            kind = (32'(bus.rx_valid) + 32'(bus.frame_err) + 32'(perr) > 1) ? K_MULTI :
                   bus.rx_valid ? K_VALID : bus.frame_err ? K_FERR : K_PERR;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b ferr=%0b perr=%0b data=%0h, expected no pulse",
                         bus.rx_valid, bus.frame_err, perr, bus.rx_data);
            end else begin
                e = exp_q.pop_front();
                if ({kind, bus.rx_data} !== e) begin
                    errors++;
                    $display("FAIL frame_result: got kind=%0d data=%0h, expected kind=%0d data=%0h",
                             kind, bus.rx_data, e[9:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       par, stop;
        int         gap;

        bus.rx_serial = 1'b1;
        wait_clk(5);
        check("reset_rx_data", 32'(bus.rx_data), 0);
        check("reset_rx_valid", 32'(bus.rx_valid), 0);
        check("reset_frame_err", 32'(bus.frame_err), 0);
        check("reset_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        wait_clk(20);

        // Single good byte.
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_clk(BIT_CLK);
        check("busy_after_a5", 32'(bus.busy), 0);
        check("data_after_a5", 32'(bus.rx_data), 32'h A5);

        // Short glitch shorter than half a bit.
        bus.rx_serial = 1'b0;
        wait_clk(20);
        bus.rx_serial = 1'b1;
        wait_clk(40);
        check("busy_after_glitch", 32'(bus.busy), 0);
        check("data_after_glitch", 32'(bus.rx_data), 32'h A5);

        // Framing error followed by a stuck-low line, then recovery.
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clk(300);
        check("data_after_ferr", 32'(bus.rx_data), 32'h A5);
        bus.rx_serial = 1'b1;
        wait_clk(BIT_CLK);
        send_frame(8'h81, 1'b0, 1'b1);
        wait_clk(BIT_CLK);
        check("data_after_81", 32'(bus.rx_data), 32'h81);

        // Zero-gap back-to-back frames.
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        check("queue_drained_b2b", 32'(exp_q.size()), 0);

        // Reset in the middle of bit 4 of 0x96; no model entry for the partial frame.
        d = 8'h96;
        bus.rx_serial = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            bus.rx_serial = d[i];
            wait_clk(BIT_CLK);
        end
        bus.rx_serial = d[4];
        wait_clk(BIT_CLK / 2);
        rst = 1'b1;
        wait_clk(1);
        check("midreset_rx_data", 32'(bus.rx_data), 0);
        check("midreset_rx_valid", 32'(bus.rx_valid), 0);
        check("midreset_frame_err", 32'(bus.frame_err), 0);
        check("midreset_busy", 32'(bus.busy), 0);
        last_good = 8'h00;
        bus.rx_serial = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(BIT_CLK);
        send_frame(8'h69, 1'b0, 1'b1);
        wait_clk(BIT_CLK);
        check("data_after_69", 32'(bus.rx_data), 32'h69);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity bit 1 is correct.
        send_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b0, 1'b1);
        wait_clk(BIT_CLK);
        check("data_after_parity", 32'(bus.rx_data), 32'h07);
`endif

        // Randomized frames with random gaps and occasional bad stop bits.
        for (int n = 0; n < 20; n++) begin
            d    = 8'($urandom_range(0, 255));
            par  = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, par, stop);
            gap = stop ? $urandom_range(0, 80) : BIT_CLK + $urandom_range(0, 40);
            if (!stop) begin
                wait_clk(BIT_CLK / 2);
            end
            bus.rx_serial = 1'b1;
            wait_clk(gap);
        end

        wait_clk(4 * BIT_CLK);
        check("queue_drained_final", 32'(exp_q.size()), 0);
        check("busy_final", 32'(bus.busy), 0);
        check("data_final", 32'(bus.rx_data), 32'(last_good));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
